// File: rtl/btb_pkg.sv
// Shared types and defaults for the BTB update path: the queued update payload
// and the resolve-outcome classification helper.
package btb_pkg;

  localparam int unsigned BTB_FIFO_DEPTH_DEF = 4;
  localparam int unsigned BTB_STARVE_MAX_DEF = 15;

  typedef struct packed {
    logic        invalid;
    logic [31:1] pc;
    logic [31:0] target;
  } btb_upd_t;

  localparam int unsigned BTB_UPD_W = $bits(btb_upd_t);

  // A BTB write is needed when a taken branch was missed or mistargeted,
  // or when a not-taken branch still has a live BTB entry.
  function automatic logic needs_update(input logic        taken,
                                        input logic        pred_hit,
                                        input logic [31:1] pred_target,
                                        input logic [31:0] target);
    if (taken) return !pred_hit || (pred_target != target[31:1]);
    return pred_hit;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock in-order FIFO with registered storage and combinational head.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Extra MSB on each pointer distinguishes full from empty after wrap.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/btb_update.sv
// Queues BTB allocate/retarget/invalidate updates from branch resolution and
// drives them onto the shared BTB port, yielding to fetch until starved.
// Optional BTB_UPDATE_STATS_EN adds write/invalidate/forced-write counters.
module btb_update
  import btb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = BTB_FIFO_DEPTH_DEF,
  parameter int unsigned STARVE_MAX = BTB_STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        resolve_valid,
  output logic        resolve_ready,
  input  logic [31:1] resolve_pc,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_pred_hit,
  input  logic [31:1] resolve_pred_target,
  input  logic        fetch_btb_rd,
  output logic        btb_rd_kill,
  output logic        btb_wr,
  output logic        btb_invalid,
  output logic [31:1] pc_w,
  output logic [31:0] target_pc_w
`ifdef BTB_UPDATE_STATS_EN
  ,
  output logic [31:0] stat_wr_cnt,
  output logic [31:0] stat_inv_cnt,
  output logic [31:0] stat_force_cnt
`endif
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  btb_upd_t        w_new;
  btb_upd_t        w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_starved;
  logic [SW-1:0]   r_starve_cnt;

  assign w_new.invalid = ~resolve_taken;
  assign w_new.pc      = resolve_pc;
  assign w_new.target  = resolve_target;

  assign resolve_ready = ~w_full;
  assign w_push = resolve_valid & ~w_full &
                  needs_update(resolve_taken, resolve_pred_hit,
                               resolve_pred_target, resolve_target);

  assign w_starved = (r_starve_cnt == SW'(STARVE_MAX));
  // No write during the reset cycle; queued updates are dropped instead.
  assign w_pop = ~reset & ~w_empty & (~fetch_btb_rd | w_starved);

  sync_fifo #(
    .WIDTH (BTB_UPD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_new),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Write port: head fields on a write, all zero otherwise.
  always_comb begin
    btb_wr      = 1'b0;
    btb_invalid = 1'b0;
    btb_rd_kill = 1'b0;
    pc_w        = '0;
    target_pc_w = '0;
    if (w_pop) begin
      btb_wr      = 1'b1;
      btb_invalid = w_head.invalid;
      btb_rd_kill = fetch_btb_rd;
      pc_w        = w_head.pc;
      target_pc_w = w_head.target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_empty || w_pop) r_starve_cnt <= '0;
    else                           r_starve_cnt <= r_starve_cnt + SW'(1);
  end

`ifdef BTB_UPDATE_STATS_EN
  logic [31:0] r_stat_wr;
  logic [31:0] r_stat_inv;
  logic [31:0] r_stat_force;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_wr    <= '0;
      r_stat_inv   <= '0;
      r_stat_force <= '0;
    end else begin
      if (btb_wr)      r_stat_wr    <= r_stat_wr + 32'd1;
      if (btb_invalid) r_stat_inv   <= r_stat_inv + 32'd1;
      if (btb_rd_kill) r_stat_force <= r_stat_force + 32'd1;
    end
  end

  assign stat_wr_cnt    = r_stat_wr;
  assign stat_inv_cnt   = r_stat_inv;
  assign stat_force_cnt = r_stat_force;
`endif

endmodule

// File: doc/btb_update.md
# btb_update

Branch-resolution side of the branch target buffer. It takes resolved control-transfer outcomes from execute and decides whether each one needs a BTB allocate, retarget or invalidate. Required updates are queued and then driven onto the BTB write port (`btb_wr`/`btb_invalid`/`pc_w`/`target_pc_w`). The BTB shares its single memory port between lookup and write, and a write overrides the lookup address, so this block yields to fetch lookups and forces a write only when starvation reaches its limit.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: update queue entries, power of two, ≥2.
- `STARVE_MAX`, 15: consecutive blocked cycles before a write is forced; ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  synchronous active-high reset.
- `resolve_valid`  in  1  execute presents a resolved branch or jump.
- `resolve_ready`  out  1  `!full`; a transfer happens when valid & ready.
- `resolve_pc`  in  [31:1]  pc of the resolved instruction.
- `resolve_taken`  in  1  actual direction.
- `resolve_target`  in  [31:0]  actual target.
- `resolve_pred_hit`  in  1  BTB hit reported at fetch for this instruction.
- `resolve_pred_target`  in  [31:1]  target predicted at fetch.
- `fetch_btb_rd`  in  1  fetch's BTB lookup request this cycle.
- `btb_rd_kill`  out  1  the lookup this cycle is overridden; fetch discards next-cycle `btb_hit` and replays.
- `btb_wr`  out  1  BTB write strobe.
- `btb_invalid`  out  1  write clears the entry's valid bit.
- `pc_w`  out  [31:1]  write pc.
- `target_pc_w`  out  [31:0]  write target.

## Operation
Classification happens on transfer:
- taken & (!pred_hit | pred_target ≠ target[31:1]): enqueue {invalid=0, pc, target}.
- !taken & pred_hit: enqueue {invalid=1, pc, target}.
- All other cases: the transfer is consumed and nothing is enqueued.

Queue and arbitration:
- In-order FIFO, no coalescing. Duplicate pcs are written in order, so the last one wins.
- When the FIFO is full, `resolve_ready`=0 even if a pop happens in the same cycle. There is no pass-through when full.
- When the FIFO is non-empty and `fetch_btb_rd`=0: `btb_wr`=1 with the head fields, pop, and clear `starve_cnt`.
- When the FIFO is non-empty, `fetch_btb_rd`=1 and `starve_cnt`<STARVE_MAX: no write, and `starve_cnt`+1.
- When the FIFO is non-empty, `fetch_btb_rd`=1 and `starve_cnt`==STARVE_MAX: forced write. `btb_wr`=1, `btb_rd_kill`=1, pop, and clear `starve_cnt`.
- When the FIFO is empty: `starve_cnt` is held at 0.
- `btb_rd_kill` is asserted only on a forced write.
- `starve_cnt` width is $clog2(STARVE_MAX+1).

## Timing
- Write port outputs are combinational from the FIFO head and `fetch_btb_rd`. Fields are 0 when `btb_wr`=0.
- Latency: an entry accepted in cycle N is written in cycle N+1 at the earliest. Same-cycle bypass does not exist.
- Worst-case wait for the head entry: STARVE_MAX+1 cycles.
- Reset values: `btb_wr`=0, `btb_invalid`=0, `pc_w`=0, `target_pc_w`=0, `btb_rd_kill`=0, `resolve_ready`=1. FIFO is empty and `starve_cnt`=0.
- Reset mid-operation drops all queued updates. No write is issued in the reset cycle. This is safe because stale BTB entries only cause mispredictions.
- A simultaneous push and pop in the non-full state leaves the occupancy unchanged.
- Pointers wrap modulo FIFO_DEPTH.

## Configuration
- `BTB_UPDATE_STATS_EN` defined: adds 32-bit wrapping counters as outputs.
  - `stat_wr_cnt` counts every `btb_wr`.
  - `stat_inv_cnt` counts writes with `btb_invalid`=1.
  - `stat_force_cnt` counts writes with `btb_rd_kill`=1.
  - All counters reset to 0.
- Not defined: the counter ports and logic are absent, and the remaining behaviour is identical.

## Structure
- Shared package `btb_pkg` holds:
  - struct `btb_upd_t` {invalid, pc[31:1], target[31:0]}.
  - localparam defaults for FIFO_DEPTH and STARVE_MAX.
- Sub-module `sync_fifo` is parameterized by width and depth, with push/pop/full/empty and head data. It is instantiated once with `btb_upd_t`.

## Test plan
- Misprediction allocate: pc=0x1000>>1, taken, target=0x2000, pred_hit=0, fetch idle. Next cycle: `btb_wr`=1, `btb_invalid`=0, `pc_w`=0x800, `target_pc_w`=0x2000.
- Stale entry: not taken, pred_hit=1, pc=0x1040>>1. Next cycle: `btb_wr`=1, `btb_invalid`=1, `pc_w`=0x820.
- Correct prediction: taken, pred_hit=1, pred_target=0x2000>>1, target=0x2000. The transfer is accepted, with no `btb_wr` ever and the FIFO staying empty.
- Starvation: one entry queued, `fetch_btb_rd` held at 1 with STARVE_MAX=15. No write for 15 cycles; on the 16th cycle `btb_wr`=`btb_rd_kill`=1. Then enqueue a second entry: it gets a fresh 15-cycle count.
- Backpressure: five required updates back-to-back, FIFO_DEPTH=4, fetch busy. `resolve_ready` drops after 4 transfers. The fifth entry is accepted only in the cycle after the first pop, and write order matches input order.
- Reset mid-operation: 3 entries queued, then `reset` held for 1 cycle. Afterwards: no `btb_wr`, `resolve_ready`=1, and the stats counters (if `BTB_UPDATE_STATS_EN`) read 0.
